// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard/stall/flush controller with multi-cycle mul/div sequencing
//
// Purpose: derives the pipeline register load enables and bubble-insert requests
// for a 5-stage pipeline from the hazard inputs, and sequences multi-cycle
// mul/div operations that hold the EX stage.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   load_use                  ID consumes the result of a load currently in EX
//   muldiv_start              EX holds a mul/div instruction
//   mem_stall                 data memory not ready for the MEM-stage access
//   branch_redirect           EX resolved a taken/mispredicted branch
//   exception                 MEM-stage instruction raised an exception
//   pc_en .. mem_wb_en        pipeline register load enables
//   if_id_flush .. mem_wb_flush  synchronous bubble insert (register loads NOP when enabled)
//   muldiv_busy               mul/div sequence in progress
//   muldiv_done               one-cycle pulse, mul/div result may advance
//   muldiv_cancel             one-cycle pulse, abort the mul/div unit
//   stall_count               free-running count of cycles with pc_en=0
module pipeline_ctrl #(
  parameter int MULDIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        muldiv_start,
  input  logic        mem_stall,
  input  logic        branch_redirect,
  input  logic        exception,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic        muldiv_cancel,
  output logic [31:0] stall_count
);

  localparam int CW = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MULDIV = 1'b1;

  // The accepting cycle in RUN is itself the first stall cycle, so the
  // counter only has to cover the remaining MULDIV_LATENCY-1 cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LATENCY - 1);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic in_md;
  logic cnt_nz;
  logic mstall;

  assign in_md  = (state == MULDIV);
  assign cnt_nz = (cnt != '0);
  assign mstall = (!in_md && muldiv_start) || (in_md && cnt_nz);

  // Hazard resolution, highest priority first. Everything is gated by rst so
  // the pipeline is frozen while reset is held.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    muldiv_busy   = in_md;
    muldiv_done   = in_md && !cnt_nz && !mem_stall && !exception;
    muldiv_cancel = in_md && exception;

    if (exception) begin
      // Squash everything younger than the faulting MEM instruction.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze up to MEM; WB drains and receives a bubble.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mstall) begin
      // EX held by the mul/div; MEM gets a bubble behind it.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (branch_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_flush  = 1'b0;
      muldiv_busy   = 1'b0;
      muldiv_done   = 1'b0;
      muldiv_cancel = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!in_md) begin
      // A start blocked by mem_stall or an exception is simply retried later.
      if (muldiv_start && !mem_stall && !exception) begin
        state_nxt = MULDIV;
        cnt_nxt   = CNT_LOAD;
      end
    end else if (exception) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (cnt_nz) begin
      // Counts down through mem_stall cycles too; the unit keeps computing.
      cnt_nxt = cnt - 1'b1;
    end else if (!mem_stall) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_en) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_use = 1'b0;
  logic        muldiv_start = 1'b0;
  logic        mem_stall = 1'b0;
  logic        branch_redirect = 1'b0;
  logic        exception = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        muldiv_busy, muldiv_done, muldiv_cancel;
  logic [31:0] stall_count;

  pipeline_ctrl #(.MULDIV_LATENCY(L)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use        (load_use),
    .muldiv_start    (muldiv_start),
    .mem_stall       (mem_stall),
    .branch_redirect (branch_redirect),
    .exception       (exception),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_flush    (mem_wb_flush),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done),
    .muldiv_cancel   (muldiv_cancel),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: busy flag plus the number of stall cycles still owed.
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_sc   = '0;
  logic [11:0] sb_q[$];
  logic [11:0] obs;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush, busy, done, cancel}
  function automatic logic [11:0] model_out(input logic r, lu, ms, mem, br, ex);
    logic [4:0] en;
    logic [3:0] fl;
    logic       mst, dn, cn;
    if (r) return 12'h000;
    en  = 5'b11111;
    fl  = 4'b0000;
    mst = (!m_busy && ms) || (m_busy && m_left > 0);
    dn  = m_busy && m_left == 0 && !mem && !ex;
    cn  = m_busy && ex;
    if (ex)        fl = 4'b1110;
    else if (mem)  begin en = 5'b00001; fl = 4'b0001; end
    else if (mst)  begin en = 5'b00011; fl = 4'b0010; end
    else if (br)   fl = 4'b1100;
    else if (lu)   begin en = 5'b00111; fl = 4'b0100; end
    return {en, fl, m_busy, dn, cn};
  endfunction

  task automatic step(input logic r, lu, ms, mem, br, ex);
    logic [11:0] e;
    @(negedge clk);
    rst = r; load_use = lu; muldiv_start = ms; mem_stall = mem;
    branch_redirect = br; exception = ex;
    if (r) begin m_busy = 1'b0; m_left = 0; m_sc = '0; end
    e = model_out(r, lu, ms, mem, br, ex);
    sb_q.push_back(e);
    #1;
    obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           muldiv_busy, muldiv_done, muldiv_cancel};
    if (sb_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
    else check("outputs", {20'd0, obs}, {20'd0, sb_q.pop_front()});
    @(posedge clk);
    if (!r) begin
      if (!e[11]) m_sc = m_sc + 32'd1;
      if (!m_busy) begin
        if (ms && !mem && !ex) begin m_busy = 1'b1; m_left = L - 1; end
      end else if (ex) begin
        m_busy = 1'b0; m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (!mem) begin
        m_busy = 1'b0;
      end
    end
    #1;
    check("stall_count", stall_count, m_sc);
  endtask

  logic [31:0] sc0;

  initial begin
    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1);
    check("rst_all_zero", {20'd0, obs}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("idle_en", {27'd0, obs[11:7]}, 32'h1F);

    // plain mul/div, start held L+1 cycles
    sc0 = stall_count;
    for (int i = 0; i < L + 1; i++) begin
      step(0, 0, 1, 0, 0, 0);
      if (i < L) check("md_pc_stall", {31'd0, obs[11]}, 32'd0);
    end
    check("md_done", {31'd0, obs[1]}, 32'd1);
    check("md_all_en", {27'd0, obs[11:7]}, 32'h1F);
    check("md_sc_delta", stall_count - sc0, 32'd4);

    // load-use, alone and with redirect
    step(0, 1, 0, 0, 0, 0);
    check("lu_vec", {20'd0, obs}, {20'd0, 12'b00111_0100_000});
    step(0, 1, 0, 0, 1, 0);
    check("lu_br_vec", {20'd0, obs}, {20'd0, 12'b11111_1100_000});
    step(0, 0, 0, 0, 1, 0);

    // mem_stall on cycles 2-7 of a mul/div
    for (int i = 1; i <= 8; i++) step(0, 0, 1, (i >= 2 && i <= 7), 0, 0);
    check("ms_defer_done", {31'd0, obs[1]}, 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // exception with mem_stall on cycle 2
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1);
    check("exc_vec", {20'd0, obs}, {20'd0, 12'b11111_1110_101});
    step(0, 0, 0, 0, 0, 0);
    check("exc_busy_after", {31'd0, obs[2]}, 32'd0);

    // start blocked by mem_stall, then accepted; start with redirect
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < L + 1; i++) step(0, 0, 1, 0, (i == 0), 0);
    step(0, 0, 0, 0, 0, 0);

    // stall_count wrap
    force dut.stall_count = 32'hFFFF_FFFE;
    #1 release dut.stall_count;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    check("sc_wrap", stall_count, 32'h0000_0001);

    // reset mid mul/div
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("rst_mid_zero", {20'd0, obs}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_mid_run", {29'd0, obs[2:0]}, 32'd0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LATENCY, default 32, the number of stall cycles a mul/div holds EX (legal range 1..255).
REQ-002 SHALL have ports:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  reset, asynchronous, active-high
  load_use  in  1  ID instruction consumes result of load in EX
  muldiv_start  in  1  EX holds a mul/div instruction
  mem_stall  in  1  data memory not ready for MEM-stage access
  branch_redirect  in  1  EX resolved taken/mispredicted branch
  exception  in  1  MEM-stage instruction raised exception
  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  synchronous bubble insert (register loads NOP when enabled)
  muldiv_busy  out  1  mul/div sequence in progress
  muldiv_done  out  1  one-cycle pulse, result may advance
  muldiv_cancel  out  1  one-cycle pulse, abort mul/div unit
  stall_count  out  32  cycles with pc_en=0
REQ-003 SHALL drive flush outputs as synchronous data-path requests only; never tied to pipeline register async reset.

Function
REQ-004 SHALL keep FSM states RUN and MULDIV plus down-counter cnt of width ceil(log2(MULDIV_LATENCY)) minimum 1.
REQ-005 Enables/flushes SHALL be combinational from state, cnt and inputs, resolved by fixed priority (highest first) per REQ-006..REQ-011; no condition active -> all enables 1, all flushes 0.
REQ-006 exception: all enables 1; if_id_flush, id_ex_flush, ex_mem_flush 1; mem_wb_flush 0; overrides mem_stall and muldiv.
REQ-007 mem_stall: pc_en, if_id_en, id_ex_en, ex_mem_en 0; mem_wb_en 1 with mem_wb_flush 1.
REQ-008 muldiv stall (mstall = (RUN & muldiv_start) | (MULDIV & cnt!=0)): pc_en, if_id_en, id_ex_en 0; ex_mem_en 1 with ex_mem_flush 1; mem_wb_en 1.
REQ-009 branch_redirect: all enables 1; if_id_flush, id_ex_flush 1.
REQ-010 load_use: pc_en, if_id_en 0; id_ex_en 1 with id_ex_flush 1; others enabled.
REQ-011 branch_redirect with load_use: redirect wins. branch_redirect with muldiv_start is a protocol violation; muldiv wins.
REQ-012 RUN -> MULDIV when muldiv_start & !mem_stall & !exception; cnt loads MULDIV_LATENCY-1. muldiv_start blocked by mem_stall is not accepted; retried next cycle.
REQ-013 In MULDIV, cnt decrements each cycle while cnt!=0, including mem_stall cycles; cnt saturates at 0.
REQ-014 In MULDIV with cnt==0 and !mem_stall and !exception: muldiv_done=1, no mstall, next state RUN; with mem_stall, remain MULDIV cnt 0, done deferred.
REQ-015 muldiv_start SHALL be ignored in MULDIV state.
REQ-016 exception while MULDIV: muldiv_cancel=1 that cycle, next state RUN, cnt 0; no muldiv_done.
REQ-017 muldiv_busy = (state==MULDIV).
REQ-018 Mul/div with no other events: exactly MULDIV_LATENCY stalled cycles, advancing on the (MULDIV_LATENCY+1)th cycle in EX.
REQ-019 stall_count SHALL increment on every rising edge with pc_en=0 and rst=0; wraps 0xFFFFFFFF -> 0.

Reset
REQ-020 rst high SHALL immediately force state RUN, cnt 0, stall_count 0.
REQ-021 While rst high all enables, flushes, muldiv_busy, muldiv_done, muldiv_cancel SHALL be 0.
REQ-022 rst asserted mid mul/div SHALL abandon it without muldiv_cancel; first cycle after release is RUN.

Verification
REQ-023 MULDIV_LATENCY=4, muldiv_start held 5 cycles -> pc_en 0 for cycles 1-4, muldiv_done and all enables 1 on cycle 5, stall_count +4.
REQ-024 load_use 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; load_use with branch_redirect same cycle -> pc_en=1, if_id_flush=id_ex_flush=1.
REQ-025 LATENCY=4, mem_stall held cycles 2-7 of mul/div -> cnt reaches 0, done deferred, muldiv_done in first cycle mem_stall=0, EX->MEM bubble only in non-mem_stall stall cycles.
REQ-026 exception on cycle 2 of mul/div with mem_stall=1 -> muldiv_cancel=1, if_id/id_ex/ex_mem flush=1, all enables 1, next cycle muldiv_busy=0.
REQ-027 stall_count forced near 0xFFFFFFFE, 3 stall cycles -> reads 0x00000001; rst pulse mid-MULDIV -> outputs 0 during rst, RUN after.
